// File: rtl/bit_split.sv
// bit_split: splits each 2*WIDTH-bit input word into two WIDTH-bit output halves, upper half first.
module bit_split #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [2*WIDTH-1:0] in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_first,
    output logic [7:0]         words_done
);
    typedef enum logic [1:0] {IDLE, SEND_HI, SEND_LO} state_t;
    state_t             state_q, state_d;
    logic [2*WIDTH-1:0] word_q, word_d;
    logic [7:0]         done_q, done_d;
    logic               in_fire, out_fire;
    always_comb begin
        in_ready   = state_q == IDLE || (state_q == SEND_LO && out_ready);
        out_valid  = state_q != IDLE;
        out_first  = state_q == SEND_HI;
        out_data   = state_q == SEND_HI ? word_q[2*WIDTH-1:WIDTH] : word_q[WIDTH-1:0];
        words_done = done_q;
        in_fire    = in_valid && in_ready;
        out_fire   = out_valid && out_ready;
        word_d     = in_fire ? in_data : word_q;
        done_d     = done_q + {7'd0, state_q == SEND_LO && out_fire};
        state_d    = state_q == IDLE    ? (in_fire ? SEND_HI : IDLE) :
                     state_q == SEND_HI ? (out_fire ? SEND_LO : SEND_HI) :
                     out_fire           ? (in_fire ? SEND_HI : IDLE) : SEND_LO;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            word_q  <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            done_q  <= done_d;
        end
    end
endmodule
